mod_exp_unit: RTL and testbench
===============================

// Module: mod_exp_unit
// PURPOSE
//  Sequential modular exponentiator: result = base^exponent mod modulus.
//  Produces the per-prime half-results (c^dp mod p, c^dq mod q) that feed the
//  CRT recombination stage, which consumes p, q, d and emits t, qinv, m, h.
//  Uses square-and-multiply over a bit-serial shift-add modular multiplier.
// PARAMETERS
//  WIDTH      32   operand width of base, exponent, modulus and result
// PORTS
//  clk        in   1      rising-edge clock; the block's only clock
//  rst_n      in   1      synchronous active-low reset, sampled on clk
//  start      in   1      request; sampled only in IDLE
//  base       in   WIDTH  must be < modulus; sampled with start
//  exponent   in   WIDTH  sampled with start
//  modulus    in   WIDTH  sampled with start; 0 is illegal
//  busy       out  1      high from the cycle after start is accepted until done
//  done       out  1      one-cycle pulse; result/err valid in that cycle and held after
//  err        out  1      set with done when modulus==0 or base>=modulus
//  result     out  WIDTH  exponentiation result; held until next accepted start
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; busy=0, done=0, err=0, result=0. Wins over
//    everything; mid-operation reset aborts with no done pulse.
//  - States: IDLE -> LOAD -> {MUL -> SQR} x WIDTH bits -> FIN -> IDLE; IDLE -> FIN on error.
//  - IDLE: start=1 latches inputs, goes to LOAD. start while busy is ignored (no queue).
//  - LOAD (1 cycle): acc=1 mod modulus (0 if modulus==1), b=base, e=exponent; busy=1.
//    If modulus==0 or base>=modulus: go to FIN with err=1, result=0.
//  - MUL (WIDTH cycles): tmp=acc*b mod modulus; at end acc=tmp if e[0]==1, else acc unchanged.
//  - SQR (WIDTH cycles): b=b*b mod modulus; then e>>=1, bit counter++; after WIDTH bits -> FIN.
//  - FIN (1 cycle): result=acc (or 0 on error), done=1, busy=0; next cycle IDLE.
//  - Modular multiply x*y mod n, MSB first over y: r=2r; if r>=n r-=n; if y[i] r+=x;
//    if r>=n r-=n. One bit per cycle, r held in WIDTH+1 bits (no overflow when n near 2^WIDTH).
//  - Latency (default): done asserted exactly 2*WIDTH*WIDTH+2 cycles after the start edge
//    (2050 for WIDTH=32), independent of data. Error path: done 2 cycles after start.
//  - exponent==0 -> result=1 (0 when modulus==1). base==0, exponent>0 -> 0.
//  - start asserted in the same cycle as done/FIN is ignored; accepted next in IDLE.
// CONFIGURATION
//  MODEXP_EARLY_EXIT_EN defined: MUL skipped (0 cycles) when e[0]==0; FIN entered as soon as
//    remaining e==0 (after the last MUL, final SQR skipped). Latency is data-dependent.
//    Minimum is 2 cycles for exponent==0.
//  Not defined: fixed-latency, data-independent schedule above (side-channel hardened);
//    this is the default build.
// STRUCTURE
//  - rsa_pkg: RSA_WIDTH default (32), state encoding localparams (IDLE, LOAD, MUL, SQR,
//    FIN), and a ceil-log2 helper for the bit counters.
//  - Sub-module mod_mult_serial: start/done handshake, x, y, n in, product out.
//    Exactly WIDTH cycles per product; one instance, shared by MUL and SQR.
//  - Top: FSM, exponent shift register, bit counter, acc/b registers, err compare.
// TESTING
//  - 3^5 mod 7 -> result=5, err=0, done exactly 2050 cycles after start (default build).
//  - 4^13 mod 497 -> result=445; with MODEXP_EARLY_EXIT_EN done in fewer than 2050 cycles.
//  - 0xFFFFFFFE^2 mod 0xFFFFFFFF -> result=1. Exercises the WIDTH+1 intermediate.
//  - 9^0 mod 0x35 -> 1. 5^3 mod 1 -> 0. 60^2 mod 0x35 -> err=1, result=0, done at start+2.
//  - modulus=0 -> err=1, result=0, done at start+2. Second start while busy -> ignored;
//    exactly one done pulse.
//  - Start 3^5 mod 7; drop rst_n for 1 cycle at cycle 500 -> outputs 0, no done pulse.
//    Fresh start -> 5.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the modular exponentiator: default operand width, FSM state encoding
// and a ceil-log2 helper for sizing bit counters.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul,
    StSqr,
    StFin
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_exp_unit_if.sv
// Request/response bundle of the modular exponentiator.
interface mod_exp_unit_if #(
  parameter int unsigned WIDTH = rsa_pkg::RSA_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, err, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, err, result
  );
endinterface

// File: rtl/mod_exp_unit_mult.sv
// Bit-serial shift-add modular multiplier: product = x*y mod n, MSB of y first, exactly
// WIDTH cycles from the start cycle to the done cycle. Requires x < n.
module mod_mult_serial
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int unsigned CntW = clog2(WIDTH);

  logic [WIDTH-1:0] r_q, x_q, y_q, n_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] r_in, xs, ys, ns;
  logic [CntW-1:0]  idx;
  logic [WIDTH:0]   t;

  // The start cycle already processes the top bit straight from the operand inputs,
  // and the final bit is exposed combinationally, so a product spans exactly WIDTH cycles.
  always_comb begin
    r_in = start ? '0 : r_q;
    xs   = start ? x : x_q;
    ys   = start ? y : y_q;
    ns   = start ? n : n_q;
    idx  = start ? CntW'(WIDTH - 1) : cnt_q;
    t    = {r_in, 1'b0};
    if (t >= {1'b0, ns}) t = t - {1'b0, ns};
    if (ys[idx]) t = t + {1'b0, xs};
    if (t >= {1'b0, ns}) t = t - {1'b0, ns};
    product = t[WIDTH-1:0];
    done    = busy_q && (cnt_q == '0);
    busy    = busy_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      r_q    <= product;
      x_q    <= x;
      y_q    <= y;
      n_q    <= n;
      cnt_q  <= CntW'(WIDTH - 2);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      r_q   <= product;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_exp_unit.sv
// Square-and-multiply modular exponentiator: result = base^exponent mod modulus.
// Define MODEXP_EARLY_EXIT_EN for the data-dependent fast schedule; default is fixed latency.
module mod_exp_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  mod_exp_unit_if.slave bus
);
  localparam int unsigned CntW = clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, b_q, e_q, n_q, result_q;
  logic [CntW-1:0]  bitcnt_q;
  logic             busy_q, done_q, err_q;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_x, mul_p;
  logic [WIDTH-1:0] acc_init;
  logic             bad_op;

  always_comb begin
    mul_start = ((state_q == StMul) || (state_q == StSqr)) && !mul_busy;
    mul_x     = (state_q == StSqr) ? b_q : acc_q;
    acc_init  = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
    bad_op    = (n_q == '0) || (b_q >= n_q);
  end

  mod_mult_serial #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .x      (mul_x),
    .y      (b_q),
    .n      (n_q),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      bitcnt_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            b_q     <= bus.base;
            e_q     <= bus.exponent;
            n_q     <= bus.modulus;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          acc_q    <= acc_init;
          bitcnt_q <= '0;
          if (bad_op) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StFin;
          end else begin
`ifdef MODEXP_EARLY_EXIT_EN
            if (e_q == '0) begin
              result_q <= acc_init;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StFin;
            end else begin
              state_q <= e_q[0] ? StMul : StSqr;
            end
`else
            state_q <= StMul;
`endif
          end
        end
        StMul: begin
          if (mul_done) begin
            if (e_q[0]) acc_q <= mul_p;
`ifdef MODEXP_EARLY_EXIT_EN
            // Only entered with e[0]==1, so the fresh product is the running result.
            if ((e_q >> 1) == '0) begin
              result_q <= mul_p;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StFin;
            end else begin
              state_q <= StSqr;
            end
`else
            state_q <= StSqr;
`endif
          end
        end
        StSqr: begin
          if (mul_done) begin
            b_q      <= mul_p;
            e_q      <= e_q >> 1;
            bitcnt_q <= bitcnt_q + 1'b1;
`ifdef MODEXP_EARLY_EXIT_EN
            state_q <= e_q[1] ? StMul : StSqr;
`else
            if (bitcnt_q == CntW'(WIDTH - 1)) begin
              result_q <= acc_q;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StFin;
            end else begin
              state_q <= StMul;
            end
`endif
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Scoreboard bench for mod_exp_unit: directed corner cases plus random operands checked
// against an arithmetic reference model of result, err and done latency.
module tb_mod_exp_unit;
  localparam int unsigned W       = 32;
  localparam int          FullLat = 2 * W * W + 2;
`ifdef MODEXP_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
  localparam int RstAt = 50;
`else
  localparam bit Early = 1'b0;
  localparam int RstAt = 500;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_unit_if #(.WIDTH(W)) bus ();

  mod_exp_unit #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;
  int   dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] n);
    longint unsigned r, x, m;
    m = longint'(n);
    r = 64'd1 % m;
    x = longint'(b) % m;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_lat(input logic err, input logic [W-1:0] e);
    int pop, msb;
    if (err) return 2;
    if (!Early) return FullLat;
    if (e == '0) return 2;
    pop = 0;
    msb = 0;
    for (int i = 0; i < W; i++) begin
      if (e[i]) begin
        pop++;
        msb = i;
      end
    end
    return 2 + W * pop + W * msb;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", bus.result, mon_e.res);
        check("err", bus.err, mon_e.err);
        check("latency", cyc - mon_e.t0, mon_e.lat);
        check("busy_at_done", bus.busy, 1'b0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                       input bit push);
    exp_t x;
    int k;
    k = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("idle_timeout", 1'b1, 1'b0);
    x.err = (n == '0) || (b >= n);
    x.res = x.err ? '0 : ref_modexp(b, e, n);
    x.lat = ref_lat(x.err, e);
    x.t0  = cyc;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = n;
    bus.start    = 1'b1;
    if (push) exp_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < FullLat + 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 1'b0, 1'b1);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
    issue(b, e, n, 1'b1);
    wait_drain();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
    check({tag, "_result"}, bus.result, '0);
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: got no finish, expected finish before cycle 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k;
    logic [W-1:0] rb, re, rn;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    run(32'd3, 32'd5, 32'd7);
    run(32'd4, 32'd13, 32'd497);
    run(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF);
    run(32'd9, 32'd0, 32'h35);
    run(32'd5, 32'd3, 32'd1);
    run(32'd60, 32'd2, 32'h35);
    run(32'd7, 32'd3, 32'd0);
    run(32'd0, 32'd9, 32'd11);

    // A second start while busy must be dropped.
    d0 = dones;
    issue(32'd2, 32'd10, 32'd1000, 1'b1);
    repeat (20) @(negedge clk);
    bus.base     = 32'd3;
    bus.exponent = 32'd5;
    bus.modulus  = 32'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);
    check("single_done", dones - d0, 1);

    // Start presented during the done/FIN cycle must be ignored.
    issue(32'd3, 32'd5, 32'd7, 1'b1);
    k = 0;
    while (bus.done !== 1'b1 && k < FullLat + 200) begin
      @(negedge clk);
      k++;
    end
    bus.base     = 32'd2;
    bus.exponent = 32'd3;
    bus.modulus  = 32'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("fin_start_ignored", bus.busy, 1'b0);
    wait_drain();

    // Mid-operation reset aborts without a done pulse.
    d0 = dones;
    issue(32'd3, 32'd5, 32'd7, 1'b0);
    repeat (RstAt - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_outputs("abort");
    repeat (50) @(negedge clk);
    check("abort_no_done", dones - d0, 0);
    check("abort_idle", bus.busy, 1'b0);
    run(32'd3, 32'd5, 32'd7);

    for (int i = 0; i < 10; i++) begin
      rn = $urandom;
      if (i % 3 == 0) rn[W-1] = 1'b1;
      if (rn == '0) rn = 32'd1;
      rb = $urandom % rn;
      if (i == 4) rb = rn - 1'b1;
      re = $urandom;
      if (i == 2) re = $urandom_range(1, 15);
      run(rb, re, rn);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
